// File: rtl/mem_dump_reader_if.sv
// Signal bundle linking the dump reader to the data-memory read port and the byte consumer.
// master = host/memory/consumer side, slave = dump reader.
interface mem_dump_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, count, mem_rdata, out_ready,
    input  mem_rd_en, mem_addr, out_data, out_addr, out_valid, busy, done
  );

  modport slave (
    input  start, start_addr, count, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_data, out_addr, out_valid, busy, done
  );
endinterface

// File: rtl/mem_dump_reader.sv
// Data-memory dump engine: walks an address range through the shared synchronous
// read port and streams each byte, tagged with its address, over valid/ready.
module mem_dump_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input logic              clk,
  input logic              rst,
  mem_dump_reader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] cur_addr_d;
  logic [ADDR_W:0]   remaining_q;
  logic [ADDR_W:0]   remaining_d;
  logic [ADDR_W:0]   start_len_d;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

  // Explicit wrap keeps the walk correct even for a non-power-of-two DEPTH.
  assign cur_addr_d  = (cur_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : cur_addr_q + ADDR_W'(1);
  assign remaining_d = remaining_q - (ADDR_W + 1)'(1);
  assign start_len_d = (bus.count == '0) ? (ADDR_W + 1)'(DEPTH) : bus.count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            cur_addr_q  <= bus.start_addr;
            remaining_q <= start_len_d;
            busy_q      <= 1'b1;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= bus.start_addr;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // Read data for cur_addr is on mem_rdata during this cycle.
          out_data_q  <= bus.mem_rdata;
          out_addr_q  <= cur_addr_q;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            if (remaining_q == (ADDR_W + 1)'(1)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= cur_addr_d;
              state_q     <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          mem_rd_en_q <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: drives dumps against a behavioural 16x8 memory and
// checks the streamed (addr, data) list, handshake timing and reset behaviour.
module tb_mem_dump_reader;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem [16];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [3:0] cap_addr [$];
  logic [7:0] cap_data [$];
  logic [3:0] rd_addr  [$];
  int         first_valid_e;
  int         done_e;
  int         done_cnt;
  int         stab_err;
  int         idle_err;
  int         busy_fall_e;
  logic       busy0;

  mem_dump_reader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  mem_dump_reader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous read port of the data memory: one cycle of latency.
  always @(posedge clk) begin
    if (!rst) bus.mem_rdata <= '0;
    else if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  function automatic int exp_len(input logic [4:0] c);
    return (c == 5'd0) ? 16 : int'(c);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic random_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // rmode: 0 = ready held high, 1 = ready toggles 0/1, 2 = random ready.
  // sec_edge: loop index at which a second start (addr 9, count 5) is driven, -1 for none.
  task automatic do_dump(input logic [3:0] sa, input logic [4:0] cnt, input int rmode,
                         input int sec_edge);
    logic       pv, pr, r;
    logic [7:0] pd;
    logic [3:0] pa;
    cap_addr.delete(); cap_data.delete(); rd_addr.delete();
    first_valid_e = -1; done_e = -1; done_cnt = 0; stab_err = 0; idle_err = 0;
    busy_fall_e = -1; busy0 = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0; pa = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = sa; bus.count = cnt;
    bus.out_ready = (rmode == 0);
    for (int e = 0; e < 3000; e++) begin
      @(negedge clk);
      bus.start = (e == sec_edge);
      if (e == sec_edge) begin
        bus.start_addr = 4'd9;
        bus.count      = 5'd5;
      end
      if (e == 0) busy0 = bus.busy;
      if (bus.mem_rd_en) rd_addr.push_back(bus.mem_addr);
      if (pv && !pr && !(bus.out_valid && bus.out_data == pd && bus.out_addr == pa))
        stab_err++;
      if (bus.out_valid && first_valid_e < 0) first_valid_e = e;
      if (bus.done) begin
        done_cnt++;
        if (done_e < 0) done_e = e;
      end
      if (busy_fall_e >= 0 && (bus.out_valid || bus.mem_rd_en || bus.busy || bus.done))
        idle_err++;
      case (rmode)
        0:       r = 1'b1;
        1:       r = e[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (bus.out_valid && r) begin
        cap_addr.push_back(bus.out_addr);
        cap_data.push_back(bus.out_data);
      end
      pv = bus.out_valid; pr = r; pd = bus.out_data; pa = bus.out_addr;
      if (done_e >= 0 && busy_fall_e < 0 && !bus.busy) busy_fall_e = e;
      if (busy_fall_e >= 0 && e >= busy_fall_e + 4) break;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] outs;
    rst = 1'b0;
    bus.start = 1'b1; bus.start_addr = 4'd7; bus.count = 5'd3; bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      outs = {bus.mem_rd_en, bus.mem_addr, bus.out_data, bus.out_addr, bus.out_valid,
              bus.busy, bus.done, 16'h0};
      n_checks++;
      if (outs !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h, expected 0", k, outs);
      end
    end
    bus.start = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b rd_en=%b, expected 0 0", bus.busy, bus.mem_rd_en);
    end
  endtask

  task automatic test_basic();
    clear_mem(); mem[3] = 8'd2; mem[4] = 8'd10;
    do_dump(4'd3, 5'd2, 0, -1);
    n_checks++;
    if (busy_fall_e < 0) begin n_fail++; $display("FAIL basic_timeout: dump never finished"); end
    n_checks++;
    if (cap_addr.size() !== 2) begin
      n_fail++; $display("FAIL basic_len: got %0d, expected 2", cap_addr.size());
    end
    for (int i = 0; i < 2 && i < cap_addr.size(); i++) begin
      logic [3:0] ea;
      ea = 4'((3 + i) % 16);
      $display("basic byte %0d: addr=%0d data=%0d", i, cap_addr[i], cap_data[i]);
      n_checks++;
      if (cap_addr[i] !== ea || cap_data[i] !== mem[ea]) begin
        n_fail++;
        $display("FAIL basic_byte%0d: got (%0d,%0d), expected (%0d,%0d)", i, cap_addr[i],
                 cap_data[i], ea, mem[ea]);
      end
    end
    n_checks++;
    if (first_valid_e !== 2) begin
      n_fail++; $display("FAIL basic_first_valid: got edge %0d, expected 2", first_valid_e);
    end
    n_checks++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, expected 1", busy0); end
    n_checks++;
    if (done_cnt !== 1 || done_e !== 6) begin
      n_fail++;
      $display("FAIL basic_done: got %0d pulses at edge %0d, expected 1 at 6", done_cnt, done_e);
    end
    n_checks++;
    if (busy_fall_e !== 7) begin
      n_fail++; $display("FAIL basic_busy_fall: got edge %0d, expected 7", busy_fall_e);
    end
    n_checks++;
    if (idle_err !== 0) begin
      n_fail++; $display("FAIL basic_idle: got %0d active cycles, expected 0", idle_err);
    end
  endtask

  task automatic test_wrap();
    clear_mem(); mem[15] = 8'hAA; mem[0] = 8'h55;
    do_dump(4'd15, 5'd2, 0, -1);
    n_checks++;
    if (cap_addr.size() !== 2 || rd_addr.size() !== 2) begin
      n_fail++;
      $display("FAIL wrap_len: got %0d bytes %0d reads, expected 2 2", cap_addr.size(),
               rd_addr.size());
    end
    for (int i = 0; i < 2 && i < cap_addr.size() && i < rd_addr.size(); i++) begin
      logic [3:0] ea;
      ea = 4'((15 + i) % 16);
      $display("wrap byte %0d: addr=%0d data=%h", i, cap_addr[i], cap_data[i]);
      n_checks++;
      if (cap_addr[i] !== ea || cap_data[i] !== mem[ea] || rd_addr[i] !== ea) begin
        n_fail++;
        $display("FAIL wrap_byte%0d: got (%0d,%h) rd_addr %0d, expected (%0d,%h) rd_addr %0d",
                 i, cap_addr[i], cap_data[i], rd_addr[i], ea, mem[ea], ea);
      end
    end
  endtask

  task automatic test_full_backpressure();
    random_mem();
    do_dump(4'd0, 5'd0, 1, -1);
    n_checks++;
    if (cap_addr.size() !== 16) begin
      n_fail++; $display("FAIL full_len: got %0d, expected 16", cap_addr.size());
    end
    for (int i = 0; i < 16 && i < cap_addr.size(); i++) begin
      $display("full byte %0d: addr=%0d data=%h", i, cap_addr[i], cap_data[i]);
      n_checks++;
      if (cap_addr[i] !== 4'(i) || cap_data[i] !== mem[i]) begin
        n_fail++;
        $display("FAIL full_byte%0d: got (%0d,%h), expected (%0d,%h)", i, cap_addr[i],
                 cap_data[i], i, mem[i]);
      end
    end
    n_checks++;
    if (stab_err !== 0) begin
      n_fail++; $display("FAIL full_hold_stable: got %0d changes, expected 0", stab_err);
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL full_done_count: got %0d, expected 1", done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    clear_mem(); mem[3] = 8'd2; mem[4] = 8'd10; mem[9] = 8'd99;
    do_dump(4'd3, 5'd2, 0, 2);
    n_checks++;
    if (cap_addr.size() !== 2) begin
      n_fail++; $display("FAIL busy_start_len: got %0d, expected 2", cap_addr.size());
    end
    for (int i = 0; i < 2 && i < cap_addr.size(); i++) begin
      $display("busy_start byte %0d: addr=%0d data=%0d", i, cap_addr[i], cap_data[i]);
      n_checks++;
      if (cap_addr[i] !== 4'(3 + i) || cap_data[i] !== mem[3 + i]) begin
        n_fail++;
        $display("FAIL busy_start_byte%0d: got (%0d,%0d), expected (%0d,%0d)", i, cap_addr[i],
                 cap_data[i], 3 + i, mem[3 + i]);
      end
    end
    n_checks++;
    if (idle_err !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL busy_start_idle: got %0d active cycles %0d dones, expected 0 1", idle_err,
               done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit          seen;
    int          bad;
    logic [34:0] outs;
    clear_mem(); mem[3] = 8'd2; mem[4] = 8'd10;
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = 4'd3; bus.count = 5'd2; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_hold: out_valid never rose"); end
    rst = 1'b0;
    @(negedge clk);
    outs = {bus.mem_rd_en, bus.mem_addr, bus.out_data, bus.out_addr, bus.out_valid, bus.busy,
            bus.done, 16'h0};
    n_checks++;
    if (outs !== 35'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h, expected 0", outs);
    end
    rst = 1'b1; bus.out_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done || bus.out_valid || bus.busy) bad++;
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles, expected 0", bad);
    end
    do_dump(4'd3, 5'd2, 0, -1);
    n_checks++;
    if (cap_addr.size() !== 2 || done_e !== 6) begin
      n_fail++;
      $display("FAIL rstmid_redump: got %0d bytes done edge %0d, expected 2 at 6",
               cap_addr.size(), done_e);
    end
    for (int i = 0; i < 2 && i < cap_addr.size(); i++) begin
      $display("rstmid byte %0d: addr=%0d data=%0d", i, cap_addr[i], cap_data[i]);
      n_checks++;
      if (cap_addr[i] !== 4'(3 + i) || cap_data[i] !== mem[3 + i]) begin
        n_fail++;
        $display("FAIL rstmid_byte%0d: got (%0d,%0d), expected (%0d,%0d)", i, cap_addr[i],
                 cap_data[i], 3 + i, mem[3 + i]);
      end
    end
  endtask

  task automatic test_count_one();
    clear_mem(); mem[3] = 8'd2; mem[4] = 8'd10;
    // Second start lands while the reader is in DONE and must be ignored.
    do_dump(4'd4, 5'd1, 0, 3);
    n_checks++;
    if (cap_addr.size() !== 1) begin
      n_fail++; $display("FAIL one_len: got %0d, expected 1", cap_addr.size());
    end else begin
      $display("one byte 0: addr=%0d data=%0d", cap_addr[0], cap_data[0]);
      n_checks++;
      if (cap_addr[0] !== 4'd4 || cap_data[0] !== 8'd10) begin
        n_fail++;
        $display("FAIL one_byte: got (%0d,%0d), expected (4,10)", cap_addr[0], cap_data[0]);
      end
    end
    n_checks++;
    if (done_e !== 3 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL one_done: got %0d pulses at edge %0d, expected 1 at 3", done_cnt, done_e);
    end
    n_checks++;
    if (idle_err !== 0) begin
      n_fail++; $display("FAIL one_done_start_ignored: got %0d active cycles, expected 0", idle_err);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [3:0] sa;
      logic [4:0] cnt;
      int         n;
      random_mem();
      sa  = 4'($urandom_range(0, 15));
      cnt = 5'($urandom_range(0, 16));
      n   = exp_len(cnt);
      do_dump(sa, cnt, 2, -1);
      n_checks++;
      if (cap_addr.size() !== n || done_cnt !== 1 || stab_err !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_summary: got %0d bytes %0d dones %0d unstable, expected %0d 1 0",
                 it, cap_addr.size(), done_cnt, stab_err, n);
      end
      for (int i = 0; i < n && i < cap_addr.size(); i++) begin
        logic [3:0] ea;
        ea = 4'((int'(sa) + i) % 16);
        $display("rand%0d byte %0d: addr=%0d data=%h", it, i, cap_addr[i], cap_data[i]);
        n_checks++;
        if (cap_addr[i] !== ea || cap_data[i] !== mem[ea]) begin
          n_fail++;
          $display("FAIL rand%0d_byte%0d: got (%0d,%h), expected (%0d,%h)", it, i, cap_addr[i],
                   cap_data[i], ea, mem[ea]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.start_addr = '0; bus.count = '0; bus.out_ready = 1'b0;
    clear_mem();
    test_reset();
    test_basic();
    test_wrap();
    test_full_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_count_one();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Read-side counterpart to the processor's data-memory write path: walks a range of the 16x8 data memory and streams each byte out with its address.
- Uses a valid/ready handshake so benches and debug ports can inspect memory without hierarchical peeks.
- Sits beside the data memory bank and shares its synchronous read port (1-cycle read latency) with the core.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory word width.
- DEPTH, 16, number of memory words; addresses wrap modulo DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  request a dump; sampled only in IDLE.
- start_addr  input  ADDR_W  first address to read.
- count  input  ADDR_W+1  number of words; 0 is treated as DEPTH.
- mem_rd_en  output  1  read strobe to the data memory.
- mem_addr  output  ADDR_W  read address to the data memory.
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_rd_en.
- out_data  output  DATA_W  streamed byte.
- out_addr  output  ADDR_W  address of out_data.
- out_valid  output  1  out_data/out_addr valid.
- out_ready  input  1  consumer accepts the current byte.
- busy  output  1  high from start acceptance until the DONE state is left.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0: mem_rd_en, mem_addr, out_data, out_addr, out_valid, busy, done.
  - Internal cur_addr and remaining are cleared.
  - A reset mid-dump aborts immediately: no done pulse, and the partial byte is discarded.
- Reset has priority over every other input.
- States: IDLE, READ, WAIT, HOLD, DONE.
- IDLE:
  - On start=1: latch cur_addr=start_addr and remaining=(count==0 ? DEPTH : count), set busy=1, go to READ.
- READ:
  - Combinationally, mem_rd_en=1 and mem_addr=cur_addr.
  - Go to WAIT next cycle.
- WAIT:
  - mem_rd_en=0.
  - At the edge: register out_data=mem_rdata and out_addr=cur_addr, set out_valid=1, go to HOLD.
- HOLD:
  - out_valid stays 1; out_data and out_addr are held stable until accepted.
  - On out_ready=1: out_valid=0 at that edge, cur_addr=cur_addr+1 (wraps 15 to 0), remaining=remaining-1.
  - If remaining was 1, go to DONE; otherwise go to READ.
  - If out_ready=0, stay in HOLD indefinitely.
- DONE:
  - done=1 for exactly one cycle, busy=0 from the next edge, return to IDLE.
  - A start asserted during DONE is ignored; start is accepted only in IDLE.
- start while busy is ignored; start_addr and count are not re-sampled.
- mem_addr holds its last value outside READ, and mem_rd_en is never high outside READ.
- Latency:
  - First out_valid rises 2 edges after the start-accept edge.
  - With out_ready held high, one byte is delivered per 3 cycles.
  - For count N with ready held high, done is high during the cycle after edge 3N (start edge = edge 0).
- Width rules:
  - remaining is ADDR_W+1 bits so that DEPTH=16 fits.
  - Address increment is modulo DEPTH.

Test Plan:
- Basic dump: mem[3]=2, mem[4]=10, all others 0; start with start_addr=3, count=2, out_ready=1 → bytes (addr 3, data 2) and (addr 4, data 10); first out_valid 2 edges after start; done pulses once during the cycle after edge 6; busy low after that.
- Wrap-around: mem[15]=8'hAA, mem[0]=8'h55; start_addr=15, count=2 → (15, AA) then (0, 55); mem_addr sequence 15, 0.
- Full dump with backpressure: count=0; toggle out_ready 0/1 every cycle → 16 bytes at addresses 0..15 in order; out_data stable while out_valid=1 and out_ready=0; exactly one done pulse.
- Start while busy: start_addr=3, count=2, then a second start (start_addr=9, count=5) during HOLD → only addresses 3 and 4 are emitted, then idle.
- Reset mid-operation: drive rst=0 while in HOLD with out_valid=1 → all outputs 0 the next cycle, no done pulse; a fresh start then dumps correctly.
- count=1: start_addr=4 → a single byte (4, 10); done during the cycle after edge 3.
